// File: rtl/booth_mult_scheduler.sv
// Shared sequential radix-2 Booth multiplier. A round-robin arbiter in front
// serves NREQ requesters, and results return with the owner's ID over valid/ready.
module booth_mult_scheduler #(
  parameter  int N    = 8,
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [2*N-1:0]      resp_product,
  output logic                busy
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [N:0]       a_q, a_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     m_q, m_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [2*N-1:0]   prod_q, prod_d;

  logic             grant_found;
  logic [IDW-1:0]   winner;
  logic [N-1:0]     sel_a, sel_b;
  logic [N:0]       m_ext, sum;

  // Two-pass search: requesters above ptr first, then wrap around to 0..ptr.
  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    sel_a       = '0;
    sel_b       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (IDW'(i) > ptr_q)) begin
        grant_found = 1'b1;
        winner      = IDW'(i);
        sel_a       = req_a[i*N +: N];
        sel_b       = req_b[i*N +: N];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (IDW'(i) <= ptr_q)) begin
        grant_found = 1'b1;
        winner      = IDW'(i);
        sel_a       = req_a[i*N +: N];
        sel_b       = req_b[i*N +: N];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && grant_found) begin
      req_ready[winner] = 1'b1;
    end
  end

  // The extra accumulator bit keeps A - M exact even when M = -2^(N-1).
  always_comb begin
    m_ext = {m_q[N-1], m_q};
    case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d     = '0;
          q_d     = sel_b;
          m_d     = sel_a;
          q1_d    = 1'b0;
          cnt_d   = '0;
          ptr_d   = winner;
          id_d    = winner;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {sum[N], sum[N:1]};
        q_d   = {sum[0], q_q[N-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          prod_d  = {a_d[N-1:0], q_d};
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= IDW'(NREQ-1);
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      prod_q  <= prod_d;
    end
  end

  assign resp_valid   = (state_q == DONE);
  assign resp_product = prod_q;
  assign resp_id      = id_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/booth_mult_scheduler.md
# booth_mult_scheduler

Sequential radix-2 Booth multiplier shared between NREQ requesters. A round-robin arbiter grants one request at a time. An iterative datapath then performs one Booth step per clock and returns the signed 2N-bit product with the requester's ID over a valid/ready response port. The block sits between several client engines and a single shared multiplier, replacing per-client combinational multipliers.

## Interface
- N, 8: operand width in bits (signed two's complement), N >= 2
- NREQ, 4: number of requesters, NREQ >= 2; IDW = max(1, $clog2(NREQ))
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  request accepted this cycle, at most one bit set
- req_a  in  NREQ*N  multiplicands; requester k at [k*N +: N]
- req_b  in  NREQ*N  multipliers; requester k at [k*N +: N]
- resp_valid  out  1  product available
- resp_ready  in  1  consumer accepts product
- resp_id  out  IDW  index of the requester owning resp_product
- resp_product  out  2N  signed product a*b
- busy  out  1  high in RUN or DONE

## Operation
- **FSM states:** IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE arbitration:**
  - Candidates are the requesters with req_valid set.
  - Search starts at ptr+1 (mod NREQ) and picks the first set bit.
  - req_ready[winner] = 1 combinationally in the same cycle. All other req_ready bits are 0.
  - req_ready is 0 in RUN and DONE.
- **Accept (IDLE, any req_valid):**
  - Load M = req_a[winner], Q = req_b[winner], A = 0, Q_1 = 0, count = 0.
  - Set ptr = winner and id = winner.
  - Go to RUN.
- **Requester rule:** a requester holds req_a/req_b stable while its req_valid is high and it is not yet accepted.
- **RUN, one Booth step per cycle:**
  - Accumulator A is N+1 bits wide. M is sign-extended to N+1 bits.
  - {Q[0],Q_1} = 01: A = A + M. 10: A = A - M. 00/11: no change. Arithmetic is modulo 2^(N+1).
  - Then arithmetic right shift of {A,Q,Q_1} by 1, replicating A[N].
  - count increments each step. After step N (count == N-1 at the edge), go to DONE.
- **Product width:**
  - The product is {A[N-1:0], Q}, 2N bits.
  - The N+1-bit accumulator makes the result exact for all inputs, including (-2^(N-1)) * (-2^(N-1)).
- **DONE:**
  - resp_valid = 1. resp_product and resp_id are registered and held stable.
  - On resp_valid && resp_ready, return to IDLE at the next edge.
  - No new request is accepted in the cycle that completes the response. The next accept happens in IDLE.
- **Reset (asynchronous, any state, including mid-RUN):**
  - State goes to IDLE. The in-flight operation is discarded with no response.
  - ptr = NREQ-1, so requester 0 has first priority. A, Q, Q_1, M, count and id are cleared.
- **Reset values:** resp_valid 0, resp_product 0, resp_id 0, busy 0. req_ready is 0 while rst_n is low.

## Timing
- Accept handshake in cycle 0, i.e. req_valid && req_ready sampled at edge E0.
- RUN occupies cycles 1..N; Booth steps complete at edges E1..EN.
- resp_valid rises in cycle N+1 and stays high until the response handshake.
- Minimum spacing between accepts is N+2 cycles: accept, N steps, 1 DONE cycle, with resp_ready held high.
- resp_product, resp_id and resp_valid change only on clk edges or async reset. They contain no combinational path from inputs.
- req_ready depends combinationally on req_valid, state and ptr only.
- Under backpressure (resp_ready low in DONE), the block stays in DONE indefinitely with outputs stable.
- A requester that drops req_valid before being granted is simply not considered.
- ptr changes only on accept. A requester that is waiting is granted within NREQ-1 other accepts.

## Test plan
All scenarios use N=8, NREQ=4.
- **Single signed multiply:** req0 a=7, b=-3, accepted in cycle 0 -> resp_valid first high in cycle 9, resp_product=16'hFFEB, resp_id=0, busy high cycles 1-9.
- **Extreme operands:**
  - a=-128, b=-128 -> 16'h4000.
  - a=-128, b=127 -> 16'hC080.
  - a=0, b=-1 -> 16'h0000.
  - a=-1, b=-1 -> 16'h0001.
- **Round robin:** all four req_valid held high, resp_ready=1 -> grants in order 0,1,2,3,0. req_ready is one-hot, with accepts exactly 10 cycles apart. With only req1 and req3 active, grants alternate 1,3,1.
- **Backpressure:** resp_ready low for 5 cycles in DONE -> resp_valid, resp_product and resp_id stable. No req_ready is asserted. The block returns to IDLE one edge after resp_ready rises.
- **Reset mid-operation:** assert rst_n low after step 4 of an op from req2 -> all outputs immediately 0 and no response is emitted. After release with all requesters valid, req0 is granted first.
- **Exhaustive/random check:** all 65536 8-bit operand pairs, randomly distributed over requesters with random resp_ready -> every product equals the signed a*b, every resp_id matches its request, no request is lost or duplicated.
